conv33_window_gen: RTL

//   Sliding-window generator that sits directly upstream of the conv33 engine.

---
 rtl/conv33_window_gen_pkg.sv | 7 +
 rtl/conv33_window_gen_if.sv | 23 ++
 rtl/conv33_line_buf.sv | 17 +
 rtl/conv33_window_gen.sv | 65 ++++++
 4 files changed

// File: rtl/conv33_window_gen_pkg.sv
// conv33_window_gen_pkg: shared defaults for the window generator and the conv33 engine
package conv33_window_gen_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int WIN = 3;
endpackage

// File: rtl/conv33_window_gen_if.sv
// conv33_window_gen_if: pixel stream in, 3x3 window and flags out
interface conv33_window_gen_if import conv33_window_gen_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic frame_start;
  logic pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic out_valid;
  logic frame_done;
  logic [DATA_WIDTH-1:0] out_0_0, out_0_1, out_0_2;
  logic [DATA_WIDTH-1:0] out_1_0, out_1_1, out_1_2;
  logic [DATA_WIDTH-1:0] out_2_0, out_2_1, out_2_2;
  modport master (
    output frame_start, pix_valid, pix_data,
    input out_valid, frame_done,
    input out_0_0, out_0_1, out_0_2, out_1_0, out_1_1, out_1_2, out_2_0, out_2_1, out_2_2
  );
  modport slave (
    input frame_start, pix_valid, pix_data,
    output out_valid, frame_done,
    output out_0_0, out_0_1, out_0_2, out_1_0, out_1_1, out_1_2, out_2_0, out_2_1, out_2_2
  );
endinterface

// File: rtl/conv33_line_buf.sv
// conv33_line_buf: one image row of pixels, async read, sync write, storage not reset
module conv33_line_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 28,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/conv33_window_gen.sv
// conv33_window_gen: raster pixel stream to stride-1 3x3 windows for conv33
module conv33_window_gen import conv33_window_gen_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input logic clk,
  input logic rst,
  conv33_window_gen_if.slave s
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  logic [COL_W-1:0] col, c;
  logic [ROW_W-1:0] row, r;
  logic last_col, last_row, out_valid, frame_done;
  logic [DATA_WIDTH-1:0] lb0_q, lb1_q;
  logic [WIN-1:0][WIN-1:0][DATA_WIDTH-1:0] win;
  // frame_start overrides the counters combinationally so a coincident pixel lands at (0,0)
  assign c = s.frame_start ? '0 : col;
  assign r = s.frame_start ? '0 : row;
  assign last_col = c == COL_W'(IMG_W - 1);
  assign last_row = r == ROW_W'(IMG_H - 1);
  conv33_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .ADDR_W(COL_W)) lb0 (
    .clk(clk), .we(s.pix_valid), .addr(c), .wdata(lb1_q), .rdata(lb0_q)
  );
  conv33_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .ADDR_W(COL_W)) lb1 (
    .clk(clk), .we(s.pix_valid), .addr(c), .wdata(s.pix_data), .rdata(lb1_q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
      win <= '0;
    end else begin
      out_valid <= s.pix_valid && r >= ROW_W'(2) && c >= COL_W'(2);
      frame_done <= s.pix_valid && last_row && last_col;
      if (s.pix_valid) begin
        col <= last_col ? '0 : c + 1'b1;
        row <= last_col ? (last_row ? '0 : r + 1'b1) : r;
        for (int i = 0; i < WIN; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb0_q;
        win[1][2] <= lb1_q;
        win[2][2] <= s.pix_data;
      end else if (s.frame_start) begin
        col <= '0;
        row <= '0;
      end
    end
  assign s.out_valid = out_valid;
  assign s.frame_done = frame_done;
  assign s.out_0_0 = win[0][0];
  assign s.out_0_1 = win[0][1];
  assign s.out_0_2 = win[0][2];
  assign s.out_1_0 = win[1][0];
  assign s.out_1_1 = win[1][1];
  assign s.out_1_2 = win[1][2];
  assign s.out_2_0 = win[2][0];
  assign s.out_2_1 = win[2][1];
  assign s.out_2_2 = win[2][2];
endmodule
